failsafe_sequencer: RTL and testbench
=====================================

// Module: failsafe_sequencer
// PURPOSE
//   Consumes the combinational system_fault flag from the conflict monitor and drives the
//   intersection into a safe state: glitch-filtered fault confirm, all-red clearance,
//   then flashing-red fallback until the fault is cleared; hands control back to the phase
//   FSM through a timed all-red recovery. Sits between the conflict monitor and the lamp drivers.
// PARAMETERS
//   CONFIRM_CYCLES     2    consecutive high samples of system_fault required to confirm (>=1)
//   ALL_RED_CYCLES     8    steady all-red clearance time after confirm (>=1)
//   FLASH_HALF_PERIOD  4    cycles per flash_out level in FLASH (>=1)
//   RECOVER_CYCLES     8    steady all-red time before release to FSM (>=1)
//   AUTO_CLEAR_CYCLES  16   fault-free cycles for auto recovery (used only with macro)
//   CNT_W              8    width of timers and fault_count
// PORTS
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   system_fault   in   1      conflict flag from monitor, sampled every rising edge
//   fault_clear    in   1      operator clear, single-cycle pulse
//   force_all_red  out  1      1 = lamp drivers override all heads to red
//   flash_out      out  1      1 = red lamps lit in FLASH; 0 elsewhere
//   fsm_hold       out  1      1 = phase FSM frozen
//   fsm_restart    out  1      one-cycle pulse: FSM restarts from its initial phase
//   failsafe_active out 1      1 in ALL_RED, FLASH, RECOVER
//   fault_count    out  CNT_W  confirmed faults since reset, saturating at all-ones
// BEHAVIOUR
//   - Moore outputs, registered; all outputs 0 in reset; state NORMAL, timers 0.
//   - States: NORMAL, CONFIRM, ALL_RED, FLASH, RECOVER.
//   - NORMAL: outputs 0. Sample fault=1 -> CONFIRM (cnt=1); if CONFIRM_CYCLES==1 -> ALL_RED directly.
//   - CONFIRM: outputs as NORMAL. fault=0 -> NORMAL (glitch dropped, not counted);
//     fault=1 and cnt+1==CONFIRM_CYCLES -> ALL_RED, else cnt++.
//   - Entry to ALL_RED from CONFIRM/NORMAL increments fault_count (saturating).
//   - ALL_RED: force_all_red=1, fsm_hold=1, failsafe_active=1, flash_out=0;
//     exactly ALL_RED_CYCLES cycles, then FLASH regardless of fault.
//   - FLASH: force_all_red=1, fsm_hold=1; flash_out=1 for first FLASH_HALF_PERIOD cycles,
//     then toggles every FLASH_HALF_PERIOD cycles. Exit only on fault_clear=1 with
//     system_fault=0 in the same sample -> RECOVER; clear while fault=1 ignored (not queued).
//   - RECOVER: force_all_red=1, fsm_hold=1, flash_out=0; RECOVER_CYCLES cycles then NORMAL
//     with fsm_restart=1 for the first NORMAL cycle. fault=1 in any RECOVER sample ->
//     ALL_RED (timer restarts, fault_count increments, no CONFIRM filtering).
//   - fault_clear outside FLASH ignored. Timer widths: CNT_W; params must fit CNT_W.
//   - Reset asserted mid-sequence: immediate return to NORMAL, outputs 0, fault_count 0.
// CONFIGURATION
//   FAILSAFE_AUTO_RECOVER_EN defined: in FLASH, a run of AUTO_CLEAR_CYCLES consecutive
//     fault=0 samples also -> RECOVER; any fault=1 sample resets the run; fault_clear still works.
//   Not defined: FLASH exits only via fault_clear; AUTO_CLEAR_CYCLES unused.
// TESTING
//   1 fault=1 for 1 cycle in NORMAL -> CONFIRM then NORMAL; all outputs 0, fault_count 0.
//   2 fault=1 for 2 cycles -> force_all_red=1 after 2nd edge, fault_count=1; 8 cycles later
//     flash_out pattern 1111 0000 1111 ...
//   3 In FLASH: fault_clear with fault=1 -> stays FLASH; fault_clear with fault=0 -> RECOVER,
//     flash_out=0, 8 cycles later NORMAL with fsm_restart high exactly 1 cycle.
//   4 In RECOVER cycle 3 fault=1 -> ALL_RED next cycle, fault_count=2, full 8-cycle clearance.
//   5 rst_n low mid-FLASH (asynchronous, between edges) -> all outputs 0 immediately.
//   6 With FAILSAFE_AUTO_RECOVER_EN: fault low 16 cycles in FLASH -> RECOVER; a fault pulse at
//     cycle 10 restarts the 16-cycle run. fault_count saturation at 255 with CNT_W=8.

Source files
------------

// File: rtl/failsafe_if.sv
// Fault/lamp-override bundle between the conflict monitor, the failsafe
// sequencer and the lamp drivers.
interface failsafe_if #(
  parameter int CNT_W = 8
) ();
  logic             system_fault;
  logic             fault_clear;
  logic             force_all_red;
  logic             flash_out;
  logic             fsm_hold;
  logic             fsm_restart;
  logic             failsafe_active;
  logic [CNT_W-1:0] fault_count;

  modport master (
    output system_fault,
    output fault_clear,
    input  force_all_red,
    input  flash_out,
    input  fsm_hold,
    input  fsm_restart,
    input  failsafe_active,
    input  fault_count
  );

  modport slave (
    input  system_fault,
    input  fault_clear,
    output force_all_red,
    output flash_out,
    output fsm_hold,
    output fsm_restart,
    output failsafe_active,
    output fault_count
  );
endinterface

// File: rtl/failsafe_sequencer.sv
// Fault confirm, all-red clearance, flashing-red fallback and timed recovery.
// Optional FAILSAFE_AUTO_RECOVER_EN: leave FLASH after a fault-free run.
module failsafe_sequencer #(
  parameter int CONFIRM_CYCLES    = 2,
  parameter int ALL_RED_CYCLES    = 8,
  parameter int FLASH_HALF_PERIOD = 4,
  parameter int RECOVER_CYCLES    = 8,
  parameter int AUTO_CLEAR_CYCLES = 16,
  parameter int CNT_W             = 8
) (
  input logic       clk,
  input logic       rst_n,
  failsafe_if.slave bus
);

  localparam int MAXV = (1 << CNT_W) - 1;

  if (CONFIRM_CYCLES < 1 || CONFIRM_CYCLES > MAXV ||
      ALL_RED_CYCLES < 1 || ALL_RED_CYCLES > MAXV ||
      FLASH_HALF_PERIOD < 1 || FLASH_HALF_PERIOD > MAXV ||
      RECOVER_CYCLES < 1 || RECOVER_CYCLES > MAXV ||
      AUTO_CLEAR_CYCLES < 1 || AUTO_CLEAR_CYCLES > MAXV)
  begin : g_param_err
    $error("failsafe_sequencer: parameter out of range");
  end

  localparam logic [CNT_W-1:0] CF_LAST = CNT_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLASH_HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] RC_LAST = CNT_W'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_NORMAL,
    S_CONFIRM,
    S_ALL_RED,
    S_FLASH,
    S_RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             bump;
  logic             leave_flash;

  logic             far_q, far_d;
  logic             flash_q, flash_d;
  logic             restart_q, restart_d;

  logic fault;
  logic clear;

  assign fault = bus.system_fault;
  assign clear = bus.fault_clear;

`ifdef FAILSAFE_AUTO_RECOVER_EN
  localparam logic [CNT_W-1:0] AC_LAST = CNT_W'(AUTO_CLEAR_CYCLES - 1);

  logic [CNT_W-1:0] run_q, run_d;
  logic             auto_done;

  // Fault-free run length, only meaningful while in FLASH.
  always_comb begin
    run_d     = '0;
    auto_done = 1'b0;
    if (state_q == S_FLASH && !fault) begin
      if (run_q == AC_LAST) auto_done = 1'b1;
      else                  run_d     = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end

  assign leave_flash = (clear && !fault) || auto_done;
`else
  assign leave_flash = clear && !fault;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    phase_d = phase_q;
    bump    = 1'b0;
    unique case (state_q)
      S_NORMAL: begin
        if (fault) begin
          tmr_d = '0;
          if (CONFIRM_CYCLES == 1) begin
            state_d = S_ALL_RED;
            bump    = 1'b1;
          end else begin
            state_d = S_CONFIRM;
            tmr_d   = CNT_W'(1);
          end
        end
      end
      S_CONFIRM: begin
        if (!fault) begin
          state_d = S_NORMAL;
          tmr_d   = '0;
        end else if (tmr_q == CF_LAST) begin
          state_d = S_ALL_RED;
          tmr_d   = '0;
          bump    = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_ALL_RED: begin
        if (tmr_q == AR_LAST) begin
          state_d = S_FLASH;
          tmr_d   = '0;
          phase_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_FLASH: begin
        if (tmr_q == FL_LAST) begin
          tmr_d   = '0;
          phase_d = ~phase_q;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
        if (leave_flash) begin
          state_d = S_RECOVER;
          tmr_d   = '0;
          phase_d = 1'b0;
        end
      end
      S_RECOVER: begin
        // Relapse skips confirm filtering: the intersection is still unsafe.
        if (fault) begin
          state_d = S_ALL_RED;
          tmr_d   = '0;
          bump    = 1'b1;
        end else if (tmr_q == RC_LAST) begin
          state_d = S_NORMAL;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_NORMAL;
        tmr_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bump && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    far_d     = 1'b0;
    flash_d   = 1'b0;
    restart_d = 1'b0;
    unique case (1'b1)
      state_d == S_ALL_RED: far_d = 1'b1;
      state_d == S_FLASH: begin
        far_d   = 1'b1;
        flash_d = phase_d;
      end
      state_d == S_RECOVER: far_d = 1'b1;
      state_d == S_NORMAL:
        restart_d = (state_q == S_RECOVER);
      default: far_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_NORMAL;
      tmr_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      far_q     <= 1'b0;
      flash_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      far_q     <= far_d;
      flash_q   <= flash_d;
      restart_q <= restart_d;
    end
  end

  assign bus.force_all_red   = far_q;
  assign bus.fsm_hold        = far_q;
  assign bus.failsafe_active = far_q;
  assign bus.flash_out       = flash_q;
  assign bus.fsm_restart     = restart_q;
  assign bus.fault_count     = cnt_q;

endmodule

// File: tb/tb_failsafe_sequencer.sv
// Directed vector bench for failsafe_sequencer: table of per-cycle
// inputs/expected outputs plus reset, saturation and auto-recover sequences.
module tb_failsafe_sequencer;

  logic clk;
  logic rst_n;

  failsafe_if #(.CNT_W(8)) bus ();

  failsafe_sequencer #(
    .CONFIRM_CYCLES   (2),
    .ALL_RED_CYCLES   (8),
    .FLASH_HALF_PERIOD(4),
    .RECOVER_CYCLES   (8),
    .AUTO_CLEAR_CYCLES(16),
    .CNT_W            (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       f;
    logic       c;
    logic       far;
    logic       fl;
    logic       rs;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [12:0] pack(input logic far, input logic fl,
                                       input logic rs, input logic [7:0] cnt);
    return {far, fl, far, rs, far, cnt};
  endfunction

  function automatic logic [12:0] outs();
    return {bus.force_all_red, bus.flash_out, bus.fsm_hold,
            bus.fsm_restart, bus.failsafe_active, bus.fault_count};
  endfunction

  task automatic chk(input string nm, input logic [12:0] got,
                     input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (far,fl,hold,rst,act,cnt)",
               nm, got, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [7:0] exp);
    n_tests++;
    if (bus.fault_count !== exp) begin
      n_fail++;
      $display("FAIL %s fault_count got=%0d exp=%0d",
               nm, bus.fault_count, exp);
    end
  endtask

  task automatic add(input logic f, input logic c, input logic far,
                     input logic fl, input logic rs, input logic [7:0] cnt,
                     input int n = 1);
    vec_t v;
    v.f = f; v.c = c; v.far = far; v.fl = fl; v.rs = rs; v.cnt = cnt;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic step(input logic f, input logic c);
    @(negedge clk);
    bus.system_fault = f;
    bus.fault_clear  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.system_fault = 1'b0;
    bus.fault_clear  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset, then two fault samples and eight quiet ones: FLASH entry.
  task automatic go_flash();
    do_reset();
    step(1, 0);
    step(1, 0);
    repeat (8) step(0, 0);
  endtask

  initial begin
    // glitch dropped
    add(1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2);
    // confirmed fault, 8-cycle all-red, clear ignored there
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 2);
    add(0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 4);
    // flash 1111 0000 1111, clear with fault ignored
    add(0, 0, 1, 1, 0, 1);
    add(1, 0, 1, 1, 0, 1, 2);
    add(0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 1, 4);
    add(0, 0, 1, 1, 0, 1);
    add(1, 1, 1, 1, 0, 1);
    add(0, 0, 1, 1, 0, 1, 2);
    // clear -> recover, 8 cycles, restart pulse
    add(0, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 7);
    add(0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 1);
    // second fault, relapse in recover
    add(1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 2);
    add(0, 0, 1, 0, 0, 2, 7);
    add(0, 0, 1, 1, 0, 2);
    add(0, 1, 1, 0, 0, 2);
    add(0, 0, 1, 0, 0, 2, 2);
    add(1, 0, 1, 0, 0, 3);
    add(0, 0, 1, 0, 0, 3, 7);
    add(0, 0, 1, 1, 0, 3);

    rst_n = 1'b0;
    bus.system_fault = 1'b0;
    bus.fault_clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), pack(0, 0, 0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].f, vecs[i].c);
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].far, vecs[i].fl, vecs[i].rs, vecs[i].cnt));
    end

    // asynchronous reset between edges while flashing
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), pack(0, 0, 0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // saturation of fault_count via repeated relapses from recover
    step(1, 0);
    step(1, 0);
    chk_cnt("sat_first", 8'd1);
    repeat (8) step(0, 0);
    step(0, 1);
    for (int k = 1; k <= 260; k++) begin
      step(1, 0);
      if (k == 253 || k == 254 || k == 260)
        chk_cnt($sformatf("sat_k%0d", k), (k >= 254) ? 8'd255 : 8'(k + 1));
      repeat (8) step(0, 0);
      step(0, 1);
    end

    // fault-free run in FLASH, fault pulse at sample 10
    go_flash();
    chk("af_entry", outs(), pack(1, 1, 0, 8'd1));
    repeat (9) step(0, 0);
    step(1, 0);
    repeat (15) step(0, 0);
    chk("af_s25", outs(), pack(1, 1, 0, 8'd1));
    step(0, 0);
`ifdef FAILSAFE_AUTO_RECOVER_EN
    chk("af_s26_recover", outs(), pack(1, 0, 0, 8'd1));
    repeat (7) step(0, 0);
    chk("af_recover_end", outs(), pack(1, 0, 0, 8'd1));
    step(0, 0);
    chk("af_restart", outs(), pack(0, 0, 1, 8'd1));
`else
    chk("af_s26_flash", outs(), pack(1, 1, 0, 8'd1));
    repeat (10) step(0, 0);
    chk("af_s36_flash", outs(), pack(1, 0, 0, 8'd1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
